// File: rtl/owm_bit_engine.sv
// owm_bit_engine: bit-level 1-wire timing core.
// Takes one command (bus reset/presence, write bit, read bit) with its timing set,
// drives the open-drain waveform on the selected bus, samples the line and
// reports the result with a one-cycle done pulse.
//
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   clk_pclr              prescaler; one tick = clk_pclr+1 clocks
//   t_reset_*             reset low / release length / presence sample tick
//   t_write_*             write slot / write-1 low / recovery (ticks)
//   t_read_*              read slot / low / sample tick / recovery (ticks)
//   cmd_valid, cmd_ready  command handshake (ready only in IDLE)
//   cmd_type              01 reset, 10 write, 11 read, 00 dropped
//   cmd_wbit, cmd_bus     bit to write, target bus
//   busy, done            engine active, one-cycle completion pulse
//   res_presence          presence result of the last reset
//   res_rbit              sampled bit of the last read
//   ow_drv_low            per-bus pull-low enables
//   ow_in                 per-bus line level (asynchronous)
module owm_bit_engine #(
  parameter int unsigned OWM_BUS_NUM = 1,
  parameter int unsigned OW_ADDR_W   = (OWM_BUS_NUM == 1) ? 1 : $clog2(OWM_BUS_NUM),
  parameter int unsigned TW          = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [TW-1:0]          clk_pclr,
  input  logic [TW-1:0]          t_reset_l,
  input  logic [TW-1:0]          t_reset_h,
  input  logic [TW-1:0]          t_reset_pd,
  input  logic [TW-1:0]          t_write_slot,
  input  logic [TW-1:0]          t_write_l,
  input  logic [TW-1:0]          t_write_rec,
  input  logic [TW-1:0]          t_read_slot,
  input  logic [TW-1:0]          t_read_l,
  input  logic [TW-1:0]          t_read_read,
  input  logic [TW-1:0]          t_read_rec,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_type,
  input  logic                   cmd_wbit,
  input  logic [OW_ADDR_W-1:0]   cmd_bus,
  output logic                   busy,
  output logic                   done,
  output logic                   res_presence,
  output logic                   res_rbit,
  output logic [OWM_BUS_NUM-1:0] ow_drv_low,
  input  logic [OWM_BUS_NUM-1:0] ow_in
);

  localparam logic [1:0] CMD_RST = 2'b01;
  localparam logic [1:0] CMD_WR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_L,
    S_RST_H,
    S_SLOT,
    S_REC,
    S_DONE
  } state_t;

  state_t state, state_d;

  // Latched command context
  logic [1:0]           typ_q, typ_d;
  logic [OW_ADDR_W-1:0] bus_q, bus_d;
  logic [TW-1:0]        pclr_q, pclr_d;
  logic [TW-1:0]        len1_q, len1_d;   // first phase: RST_L or SLOT
  logic [TW-1:0]        len2_q, len2_d;   // second phase: RST_H or REC
  logic [TW-1:0]        low_q, low_d;     // ticks of pull-low within the first phase
  logic [TW-1:0]        samp_q, samp_d;   // sample tick (RST_H for reset, SLOT for read)

  logic [TW-1:0] presc, presc_d;
  logic [TW-1:0] tcnt, tcnt_d;

  logic [OWM_BUS_NUM-1:0] drv_d;
  logic                   done_d, presence_d, rbit_d;

  logic [OWM_BUS_NUM-1:0] sync_meta, sync_q;

  logic                   accept;
  logic                   timed;
  logic                   tick;
  logic [TW-1:0]          cur_len;
  logic                   phase_end, low_end, samp_hit;
  logic                   line;
  logic [OWM_BUS_NUM-1:0] acc_mask;

  // Zero-length timings behave as one tick.
  function automatic logic [TW-1:0] nz(input logic [TW-1:0] v);
    return (v == '0) ? TW'(1) : v;
  endfunction

  function automatic logic [TW-1:0] min_t(input logic [TW-1:0] a, input logic [TW-1:0] b);
    return (a < b) ? a : b;
  endfunction

  // Two-flop synchronizer on the asynchronous bus levels; idle bus reads high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= ow_in;
      sync_q    <= sync_meta;
    end
  end

  assign accept    = cmd_valid && cmd_ready && (cmd_type != 2'b00);
  assign timed     = (state == S_RST_L) || (state == S_RST_H) ||
                     (state == S_SLOT)  || (state == S_REC);
  assign tick      = (presc == pclr_q);
  assign cur_len   = ((state == S_RST_L) || (state == S_SLOT)) ? len1_q : len2_q;
  assign phase_end = tick && (tcnt == cur_len - TW'(1));
  assign low_end   = tick && (tcnt == low_q - TW'(1));
  assign samp_hit  = tick && (tcnt == samp_q - TW'(1));

  // Selected line level; a bus index with no physical line reads as idle high.
  always_comb begin
    line = 1'b1;
    for (int i = 0; i < OWM_BUS_NUM; i++) begin
      if (bus_q == OW_ADDR_W'(i)) line = sync_q[i];
    end
  end

  // One-hot drive mask for the requested bus; empty when the bus does not exist.
  always_comb begin
    acc_mask = '0;
    for (int i = 0; i < OWM_BUS_NUM; i++) begin
      if (cmd_bus == OW_ADDR_W'(i)) acc_mask[i] = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    typ_d      = typ_q;
    bus_d      = bus_q;
    pclr_d     = pclr_q;
    len1_d     = len1_q;
    len2_d     = len2_q;
    low_d      = low_q;
    samp_d     = samp_q;
    presc_d    = presc;
    tcnt_d     = tcnt;
    drv_d      = ow_drv_low;
    done_d     = 1'b0;
    presence_d = res_presence;
    rbit_d     = res_rbit;

    // Free-running prescaler; tick counter restarts at each phase boundary.
    if (timed) begin
      presc_d = tick ? '0 : presc + TW'(1);
      if (tick) tcnt_d = phase_end ? '0 : tcnt + TW'(1);
    end

    case (state)
      S_IDLE: begin
        if (accept) begin
          typ_d   = cmd_type;
          bus_d   = cmd_bus;
          pclr_d  = clk_pclr;
          presc_d = '0;
          tcnt_d  = '0;
          drv_d   = acc_mask;
          case (cmd_type)
            CMD_RST: begin
              len1_d  = nz(t_reset_l);
              len2_d  = nz(t_reset_h);
              low_d   = nz(t_reset_l);
              samp_d  = min_t(nz(t_reset_pd), nz(t_reset_h));
              state_d = S_RST_L;
            end
            CMD_WR: begin
              len1_d  = nz(t_write_slot);
              len2_d  = nz(t_write_rec);
              low_d   = cmd_wbit ? min_t(nz(t_write_l), nz(t_write_slot)) : nz(t_write_slot);
              samp_d  = '0;
              state_d = S_SLOT;
            end
            default: begin
              len1_d  = nz(t_read_slot);
              len2_d  = nz(t_read_rec);
              low_d   = min_t(nz(t_read_l), nz(t_read_slot));
              samp_d  = min_t(nz(t_read_read), nz(t_read_slot));
              state_d = S_SLOT;
            end
          endcase
        end
      end
      S_RST_L: begin
        if (phase_end) begin
          drv_d   = '0;
          state_d = S_RST_H;
        end
      end
      S_RST_H: begin
        if (samp_hit) presence_d = ~line;
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_SLOT: begin
        if (low_end) drv_d = '0;
        if (samp_hit && (typ_q != CMD_WR)) rbit_d = line;
        if (phase_end) begin
          drv_d   = '0;
          state_d = S_REC;
        end
      end
      S_REC: begin
        if (phase_end) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        drv_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      typ_q        <= '0;
      bus_q        <= '0;
      pclr_q       <= '0;
      len1_q       <= '0;
      len2_q       <= '0;
      low_q        <= '0;
      samp_q       <= '0;
      presc        <= '0;
      tcnt         <= '0;
      cmd_ready    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      res_presence <= 1'b0;
      res_rbit     <= 1'b1;
      ow_drv_low   <= '0;
    end else begin
      state        <= state_d;
      typ_q        <= typ_d;
      bus_q        <= bus_d;
      pclr_q       <= pclr_d;
      len1_q       <= len1_d;
      len2_q       <= len2_d;
      low_q        <= low_d;
      samp_q       <= samp_d;
      presc        <= presc_d;
      tcnt         <= tcnt_d;
      cmd_ready    <= (state_d == S_IDLE);
      busy         <= (state_d != S_IDLE);
      done         <= done_d;
      res_presence <= presence_d;
      res_rbit     <= rbit_d;
      ow_drv_low   <= drv_d;
    end
  end

endmodule

// File: doc/owm_bit_engine.md
Name: owm_bit_engine

Overview:
- Bit-level 1-wire timing core that sits directly downstream of the OWM Avalon-MM register block.
- Takes one latched command (bus reset/presence, write bit, read bit) plus the 11 timing registers.
- Generates the open-drain waveform on the selected bus and samples it.
- Returns presence/read-bit status and a done pulse; the register block turns done into STAT.ready and the IRQ.

Parameters:
- OWM_BUS_NUM, 1, number of 1-wire buses.
- OW_ADDR_W, (OWM_BUS_NUM==1)?1:$clog2(OWM_BUS_NUM), bus select width.
- TW, 16, width of each timing value.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clk_pclr  in  TW  prescaler; 1 tick = clk_pclr+1 clocks.
- t_reset_l, t_reset_h, t_reset_pd  in  TW each  reset low, release-phase length, presence sample point (ticks).
- t_write_slot, t_write_l, t_write_rec  in  TW each  write slot, write-1 low, recovery.
- t_read_slot, t_read_l, t_read_read, t_read_rec  in  TW each  read slot, low, sample point, recovery.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  01 reset, 10 write, 11 read, 00 ignored.
- cmd_wbit  in  1  bit to write.
- cmd_bus  in  OW_ADDR_W  target bus.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- res_presence  out  1  presence result of last reset.
- res_rbit  out  1  sampled bit of last read.
- ow_drv_low  out  OWM_BUS_NUM  1 = pull bus low.
- ow_in  in  OWM_BUS_NUM  bus level, asynchronous.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, res_presence=0, res_rbit=1, ow_drv_low=0, state IDLE, counters 0. All outputs are registered.
- ow_in passes through a 2-flop synchronizer; samples use the synchronized value.
- Handshake: accept when cmd_valid && cmd_ready && cmd_type!=00. On accept, latch type, wbit, bus and timings; zero the prescaler and tick counter.
- cmd_type==00 is dropped: no state change, no done.
- cmd_valid while busy is ignored.
- Prescaler counts 0..clk_pclr, wrapping; tick fires when it equals clk_pclr. clk_pclr=0 gives a tick every clock.
- tcnt counts ticks within the current phase. A phase of length N ends on its N-th tick. N=0 is treated as 1.
- States: IDLE, RST_L, RST_H, SLOT, REC, DONE.
- Reset sequence:
  - RST_L: drive low for t_reset_l ticks.
  - RST_H: release for t_reset_h ticks; on tick number t_reset_pd, capture res_presence = ~ow_in_sync.
  - If t_reset_pd >= t_reset_h, sample on the last tick instead.
  - RST_H -> DONE.
- Write slot: SLOT lasts t_write_slot ticks. Drive low for the first t_write_l ticks if wbit=1, or the whole slot if wbit=0 (clamp t_write_l to the slot). Then REC, released, for t_write_rec ticks.
- Read slot: SLOT lasts t_read_slot ticks. Drive low for the first t_read_l ticks, then release. On tick t_read_read, capture res_rbit = ow_in_sync (clamp the sample point to the last slot tick). Then REC for t_read_rec ticks.
- Drive timing: ow_drv_low[bus] rises on the clock after accept and falls on the clock after the ending tick. Only the latched bus is driven; all other bits stay 0.
- DONE lasts one cycle: done=1, then IDLE, with cmd_ready=1 on the following cycle.
- res_* hold their values until the next accepted command of the same type.
- cmd_bus >= OWM_BUS_NUM: the command is sequenced normally, no line is driven, and the sampled input is taken as 1. Result: presence=0, rbit=1.
- Asynchronous reset mid-operation: ow_drv_low clears immediately, the state returns to IDLE, and no done is issued.
- Total durations in ticks:
  - reset = t_reset_l + t_reset_h
  - write = t_write_slot + t_write_rec
  - read = t_read_slot + t_read_rec

Test Plan:
- Reset, bus 0, slave present. Setup: 10 MHz clock, timings {9,480,480,100,60,10,2,60,10,13,2}; slave pulls low 30-270 us after release. Required: ow_drv_low[0] high for exactly 4800 clocks, res_presence=1, done about 9600 clocks after accept, busy low after done.
- Reset with no slave (ow_in=1). Required: res_presence=0, same 4800/9600-clock timing.
- Write on bus 1 (OWM_BUS_NUM=2). Write 1: low for 100 clocks, done at about 620 clocks. Write 0: low for 600 clocks. ow_drv_low[0] stays 0 throughout.
- Read. Slave holds low 0-30 us: res_rbit=0. Slave idle: res_rbit=1. Sample taken at 130 clocks after slot start; done at about 620 clocks.
- cmd_valid re-asserted during busy, and cmd_type=00 in IDLE. Required: both ignored, exactly one done per accepted command.
- Edges:
  - Assert reset_n low 200 clocks into RST_L: ow_drv_low=0 at once, no done.
  - clk_pclr=0 with t_read_l=0: 1-clock low.
  - t_read_read=70 clamps the sample to slot tick 60.
